cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_pkg.sv | 7 +
 rtl/cache_arbiter_rr_arb2.sv | 16 +
 rtl/cache_arbiter.sv | 99 +++++++++
 tb/tb_cache_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, timeout default and FSM encoding for the cache arbiter
package cache_pkg;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int DEF_MAX_WAIT = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/cache_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, index 0 = instruction, 1 = data
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       last,
  output logic [1:0] gnt
);
  logic ptr;
  // ptr holds the last granted port; resetting it to data favours instruction
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= 1'b1;
    else if (adv) ptr <= last;
  assign gnt = &req ? (ptr ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises instruction and data port requests onto one cache,
// one transaction in flight, with read timeout and write-miss error reporting
module cache_arbiter
  import cache_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wline,
  output logic              d_ack,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_err,
  input  logic [LINE_W-1:0] m_line,
  output logic [31:0]       c_A,
  output logic [LINE_W-1:0] c_D,
  output logic              c_mr,
  output logic              c_mw,
  input  logic              c_hit,
  input  logic [WORD_W-1:0] c_O
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state;
  logic [31:0] addr;
  logic we, gid, active, fin;
  logic [LINE_W-1:0] wline;
  logic [CW-1:0] cnt;
  logic [1:0] gnt;
  logic [WORD_W-1:0] nrd;
  rr_arb2 u_rr (
    .clk (clk),
    .rst (rst),
    .req ({d_req, i_req}),
    .adv (state == DONE),
    .last(gid),
    .gnt (gnt)
  );
  assign active = (state == ISSUE) || (state == WAIT);
  assign c_A    = active ? addr : '0;
  assign c_D    = active ? (we ? wline : m_line) : '0;
  assign c_mr   = active & ~we;
  assign c_mw   = active & we;
  assign fin    = c_hit | we | (cnt == CW'(MAX_WAIT));
  assign nrd    = c_hit ? c_O : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr    <= '0;
      we      <= 1'b0;
      wline   <= '0;
      gid     <= 1'b0;
      cnt     <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_err   <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: if (|gnt) begin
          addr  <= gnt[1] ? d_addr : i_addr;
          we    <= gnt[1] & d_we;
          wline <= d_wline;
          gid   <= gnt[1];
          state <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (fin) begin
          state <= DONE;
          i_ack <= ~gid;
          d_ack <= gid;
          if (gid) begin
            d_err <= ~c_hit;
            // a dropped write miss leaves the last read word in place
            if (c_hit | ~we) d_rdata <= nrd;
          end else begin
            i_err   <= ~c_hit;
            i_rdata <= nrd;
          end
        end else cnt <= cnt + 1'b1;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: randomized and directed checks against a line-level cache reference
module tb_cache_arbiter;
  localparam int MW = 8;
  logic clk = 0, rst = 0;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0;
  logic [127:0] d_wline = 0, m_line = 0;
  logic i_ack, d_ack, i_err, d_err, c_mr, c_mw;
  logic [31:0] i_rdata, d_rdata, c_A;
  logic [127:0] c_D;
  logic c_hit;
  logic [31:0] c_O;
  int n_chk = 0, n_fail = 0;
  bit fill_en = 1;
  logic [127:0] cmem [logic [27:0]];
  logic [127:0] ref_mem [logic [27:0]];
  logic [127:0] ln;

  cache_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wline(d_wline),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_line(m_line), .c_A(c_A), .c_D(c_D), .c_mr(c_mr), .c_mw(c_mw),
    .c_hit(c_hit), .c_O(c_O)
  );

  always #5 clk = ~clk;

  // registered cache: read misses allocate c_D when fill_en, write misses are dropped
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_hit <= 0;
      c_O <= 0;
    end else begin
      c_hit <= 0;
      if (c_mr) begin
        if (cmem.exists(c_A[31:4])) begin
          ln = cmem[c_A[31:4]];
          c_hit <= 1;
          c_O <= ln[32*c_A[3:2] +: 32];
        end else if (fill_en) cmem[c_A[31:4]] = c_D;
      end else if (c_mw && cmem.exists(c_A[31:4])) begin
        cmem[c_A[31:4]] = c_D;
        c_hit <= 1;
        c_O <= c_D[32*c_A[3:2] +: 32];
      end
    end
  end

  function automatic void ref_txn(input bit wr, input logic [31:0] a, input logic [127:0] wl,
                                  input logic [127:0] ml, output int lat,
                                  output logic [31:0] wd, output logic er);
    logic [127:0] l;
    bit hit = ref_mem.exists(a[31:4]);
    lat = 3;
    er = 0;
    wd = 0;
    if (wr) begin
      if (hit) ref_mem[a[31:4]] = wl;
      else er = 1;
    end else begin
      if (!hit) begin
        ref_mem[a[31:4]] = ml;
        lat = 4;
      end
      l = ref_mem[a[31:4]];
      wd = l[32*a[3:2] +: 32];
    end
  endfunction

  task automatic do_txn(input bit p, input bit wr, input logic [31:0] a, input logic [127:0] wl,
                        output int n, output logic [31:0] rd, output logic er);
    bit got = 0;
    n = 0;
    if (p) begin d_req = 1; d_we = wr; d_addr = a; d_wline = wl; end
    else begin i_req = 1; i_addr = a; end
    while (!got && n < 30) begin
      @(posedge clk); #1;
      n++;
      got = p ? d_ack : i_ack;
      n_chk++;
      if ((p ? i_ack : d_ack) !== 1'b0) begin
        n_fail++;
        $display("FAIL other_ack port=%0d cycle=%0d got 1 want 0", p, n);
      end
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL ack_timeout port=%0d addr=%h no ack in %0d cycles", p, a, n);
    end
    rd = p ? d_rdata : i_rdata;
    er = p ? d_err : i_err;
    i_req = 0;
    d_req = 0;
    @(posedge clk); #1;
    n_chk++;
    if (i_ack !== 0 || d_ack !== 0) begin
      n_fail++;
      $display("FAIL ack_pulse i_ack=%b d_ack=%b want 0 0", i_ack, d_ack);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({i_ack, d_ack, i_err, d_err, c_mr, c_mw} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000000", {i_ack, d_ack, i_err, d_err, c_mr, c_mw});
    end
    n_chk++;
    if (i_rdata !== 0 || d_rdata !== 0 || c_A !== 0 || c_D !== 0) begin
      n_fail++;
      $display("FAIL reset_data i_rdata=%h d_rdata=%h c_A=%h c_D=%h want 0", i_rdata, d_rdata, c_A, c_D);
    end
    rst = 1;
  endtask

  task automatic test_directed;
    int n, lat;
    logic [31:0] rd, wd;
    logic er, eer;
    m_line = 128'h44444444_33333333_22222222_11111111;
    ref_txn(0, 32'h44, 0, m_line, lat, wd, eer);
    do_txn(0, 0, 32'h44, 0, n, rd, er);
    n_chk++;
    if (n > 6 || n != lat || rd !== 32'h22222222 || er !== 0) begin
      n_fail++;
      $display("FAIL first_read lat=%0d rd=%h err=%b want lat=%0d rd=22222222 err=0", n, rd, er, lat);
    end
    ref_txn(0, 32'h48, 0, m_line, lat, wd, eer);
    do_txn(0, 0, 32'h48, 0, n, rd, er);
    n_chk++;
    if (n != 3 || rd !== 32'h33333333 || er !== 0) begin
      n_fail++;
      $display("FAIL read_hit lat=%0d rd=%h err=%b want 3 33333333 0", n, rd, er);
    end
    ref_txn(1, 32'h40, {4{32'hAAAAAAAA}}, m_line, lat, wd, eer);
    do_txn(1, 1, 32'h40, {4{32'hAAAAAAAA}}, n, rd, er);
    n_chk++;
    if (n != 3 || er !== 0) begin
      n_fail++;
      $display("FAIL write_hit lat=%0d err=%b want 3 0", n, er);
    end
    ref_txn(0, 32'h4C, 0, m_line, lat, wd, eer);
    do_txn(1, 0, 32'h4C, 0, n, rd, er);
    n_chk++;
    if (n != 3 || rd !== 32'hAAAAAAAA || er !== 0) begin
      n_fail++;
      $display("FAIL d_read lat=%0d rd=%h err=%b want 3 aaaaaaaa 0", n, rd, er);
    end
    ref_txn(1, 32'h1000, {4{32'h5555AAAA}}, m_line, lat, wd, eer);
    do_txn(1, 1, 32'h1000, {4{32'h5555AAAA}}, n, rd, er);
    n_chk++;
    if (n != 3 || er !== 1) begin
      n_fail++;
      $display("FAIL write_miss lat=%0d err=%b want 3 1", n, er);
    end
    n_chk++;
    if (cmem.exists(28'h100) || cmem[28'h4] !== {4{32'hAAAAAAAA}}) begin
      n_fail++;
      $display("FAIL write_miss_lines alloc=%0d line40=%h want 0 aaaa..", cmem.exists(28'h100), cmem[28'h4]);
    end
  endtask

  task automatic test_timeout;
    int n;
    logic [31:0] rd;
    logic er;
    fill_en = 0;
    do_txn(0, 0, 32'h2004, 0, n, rd, er);
    n_chk++;
    if (n != MW + 3 || rd !== 0 || er !== 1) begin
      n_fail++;
      $display("FAIL timeout lat=%0d rd=%h err=%b want %0d 0 1", n, rd, er, MW + 3);
    end
    fill_en = 1;
    do_txn(1, 0, 32'h40, 0, n, rd, er);
    n_chk++;
    if (i_rdata !== 0 || i_err !== 1 || rd !== 32'hAAAAAAAA) begin
      n_fail++;
      $display("FAIL hold_rdata i_rdata=%h i_err=%b d_rdata=%h want 0 1 aaaaaaaa", i_rdata, i_err, rd);
    end
  endtask

  task automatic test_back_to_back;
    bit order[$];
    int c = 0;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    i_addr = 32'h44; d_addr = 32'h40; d_we = 0;
    i_req = 1; d_req = 1;
    while (order.size() < 3 && c < 40) begin
      @(posedge clk); #1;
      c++;
      n_chk++;
      if (i_ack && d_ack) begin
        n_fail++;
        $display("FAIL ack_overlap cycle=%0d both acks high", c);
      end
      if (i_ack) order.push_back(0);
      if (d_ack) order.push_back(1);
    end
    i_req = 0; d_req = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
      n_fail++;
      $display("FAIL rr_order got %p want '{0,1,0}", order);
    end
    n_chk++;
    if (i_rdata !== 32'hAAAAAAAA || d_rdata !== 32'hAAAAAAAA) begin
      n_fail++;
      $display("FAIL rr_data i=%h d=%h want aaaaaaaa aaaaaaaa", i_rdata, d_rdata);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit seen = 0;
    logic [31:0] rd;
    logic er;
    fill_en = 0;
    i_req = 1; i_addr = 32'h3000;
    repeat (4) @(posedge clk);
    #3;
    rst = 0;
    #1;
    n_chk++;
    if (c_mr !== 0 || c_mw !== 0 || c_A !== 0 || i_ack !== 0) begin
      n_fail++;
      $display("FAIL reset_mid c_mr=%b c_mw=%b c_A=%h i_ack=%b want 0", c_mr, c_mw, c_A, i_ack);
    end
    i_req = 0;
    @(posedge clk); #1;
    rst = 1;
    fill_en = 1;
    repeat (12) begin
      @(posedge clk); #1;
      if (i_ack || d_ack) seen = 1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_no_ack got ack after reset want none");
    end
    do_txn(0, 0, 32'h48, 0, n, rd, er);
    n_chk++;
    if (n != 3 || rd !== 32'hAAAAAAAA || er !== 0) begin
      n_fail++;
      $display("FAIL post_reset lat=%0d rd=%h err=%b want 3 aaaaaaaa 0", n, rd, er);
    end
  endtask

  task automatic test_random;
    int n, lat;
    logic [31:0] rd, wd, a;
    logic er, eer;
    bit p, wr;
    logic [127:0] wl;
    for (int k = 0; k < 40; k++) begin
      p = 1'($urandom_range(0, 1));
      wr = p & 1'($urandom_range(0, 1));
      a = 32'h100 + 32'($urandom_range(0, 7)) * 16 + 32'($urandom_range(0, 3)) * 4;
      wl = {$urandom, $urandom, $urandom, $urandom};
      m_line = {$urandom, $urandom, $urandom, $urandom};
      ref_txn(wr, a, wl, m_line, lat, wd, eer);
      do_txn(p, wr, a, wl, n, rd, er);
      n_chk++;
      if (n != lat || er !== eer || (!wr && rd !== wd)) begin
        n_fail++;
        $display("FAIL rand_%0d p=%0d we=%0d a=%h lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                 k, p, wr, a, n, rd, er, lat, wd, eer);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
